// File: rtl/div_unit.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Optional feature: define DIV_FLUSH_EN to add a `flush` input that aborts the operation in flight.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
`ifdef DIV_FLUSH_EN
  input  logic            flush,
`endif
  output logic            busy,
  output logic            done,
  output logic            wb_we_n,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
  logic [CW-1:0]   count_q;
  logic            neg_q_q, neg_r_q, op_rem_q;
  logic [4:0]      rd_q;
  logic            busy_q, done_q, wb_we_n_q;

  logic            flush_i;
  logic            accept;
  logic            is_signed, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_fix, rem_fix;

`ifdef DIV_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && start && !flush_i;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs1_data[XLEN-1];
  assign b_neg     = is_signed & rs2_data[XLEN-1];
  assign a_mag     = a_neg ? -rs1_data : rs1_data;
  assign b_mag     = b_neg ? -rs2_data : rs2_data;
  assign div_zero  = (rs2_data == '0);
  assign overflow  = is_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

  // One restoring step on the XLEN+1-bit partial remainder so a 2^31 divisor never overflows.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign quo_fix = neg_q_q ? -quo_q : quo_q;
  assign rem_fix = neg_r_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (flush_i)                      state_d = IDLE;
        else if (count_q == CW'(XLEN))    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Special cases preload their final result and skip straight to the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      count_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      op_rem_q <= 1'b0;
      rd_q     <= '0;
    end else if (accept) begin
      op_rem_q <= op[1];
      rd_q     <= rd_in;
      dvsr_q   <= b_mag;
      if (div_zero) begin
        quo_q   <= '1;
        rem_q   <= rs1_data;
        neg_q_q <= 1'b0;
        neg_r_q <= 1'b0;
        count_q <= CW'(XLEN);
      end else if (overflow) begin
        quo_q   <= {1'b1, {(XLEN-1){1'b0}}};
        rem_q   <= '0;
        neg_q_q <= 1'b0;
        neg_r_q <= 1'b0;
        count_q <= CW'(XLEN);
      end else begin
        quo_q   <= a_mag;
        rem_q   <= '0;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        count_q <= '0;
      end
    end else if ((state_q == CALC) && (count_q != CW'(XLEN))) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      count_q <= count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_we_n_q <= 1'b1;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      wb_we_n_q <= (state_d != DONE);
      if ((state_q == CALC) && (state_d == DONE)) begin
        wb_rd   <= rd_q;
        wb_data <= op_rem_q ? rem_fix : quo_fix;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
`ifdef DIV_FLUSH_EN
  assign wb_we_n = wb_we_n_q | flush;
`else
  assign wb_we_n = wb_we_n_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, randomized ops against a behavioural model,
// start-while-busy / back-to-back handling, reset abort and (with DIV_FLUSH_EN) flush.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
`ifdef DIV_FLUSH_EN
  logic        flush;
`endif
  logic        busy;
  logic        done;
  logic        wb_we_n;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests_run;
  int tests_failed;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
`ifdef DIV_FLUSH_EN
    .flush    (flush),
`endif
    .busy     (busy),
    .done     (done),
    .wb_we_n  (wb_we_n),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V divide semantics computed with plain arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one op from an idle DUT and waits (bounded) for its done pulse; called and returns at posedge+1.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] d, output logic [4:0] r, output logic we_n,
                        output int lat, output int busy_cyc, output logic after_idle);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    d = '0; r = '0; we_n = 1'b1; after_idle = 1'b0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
      if (done) break;
    end
    if (done) begin
      d = wb_data; r = wb_rd; we_n = wb_we_n;
      @(posedge clk); #1;
      after_idle = !busy && !done && wb_we_n;
    end else begin
      lat = -1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_we_n !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: busy=%b done=%b we_n=%b rd=%0d data=%h, required 0 0 1 0 0", busy, done, wb_we_n, wb_rd, wb_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_we_n !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b we_n=%b, required 0 0 1", busy, done, wb_we_n);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  ops [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    logic [4:0]  rds [8];
    logic [31:0] exp [8];
    int          lats[8];
    logic [31:0] d;
    logic [4:0]  r;
    logic        we_n, after_idle;
    int          lat, bc;
    ops  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3};
    as   = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1000};
    bs   = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd33};
    rds  = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd0};
    exp  = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd10};
    lats = '{33, 33, 33, 1, 1, 1, 1, 33};
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], rds[i], d, r, we_n, lat, bc, after_idle);
      tests_run++;
      if (lat !== lats[i]) begin
        tests_failed++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d cycles, required %0d", i, lat, lats[i]);
      end
      tests_run++;
      if (d !== exp[i] || r !== rds[i] || we_n !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL directed_result[%0d]: data=%h rd=%0d we_n=%b, required data=%h rd=%0d we_n=0", i, d, r, we_n, exp[i], rds[i]);
      end
      tests_run++;
      if (after_idle !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL directed_single_pulse[%0d]: after-done idle=%b, required 1", i, after_idle);
      end
      if (i == 0) begin
        tests_run++;
        if (bc !== 34) begin
          tests_failed++;
          $display("[TB] FAIL directed_busy_cycles: got %0d, required 34", bc);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, d;
    logic [4:0]  rd, r;
    logic        we_n, after_idle;
    int          lat, bc, mode, errs;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      rd = 5'($urandom);
      mode = $urandom_range(7);
      case (mode)
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(15, 1)) ^ (($urandom_range(1) == 1) ? 32'hFFFF_FFFF : 32'h0);
        3: a = 32'($urandom_range(100));
        default: ;
      endcase
      run_op(o, a, b, rd, d, r, we_n, lat, bc, after_idle);
      tests_run++;
      if (d !== ref_result(o, a, b) || r !== rd || we_n !== 1'b0 || lat !== ref_latency(o, a, b) || after_idle !== 1'b1) begin
        tests_failed++;
        errs++;
        if (errs < 10)
          $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: data=%h rd=%0d we_n=%b lat=%0d, required data=%h rd=%0d we_n=0 lat=%0d",
                   i, o, a, b, d, r, we_n, lat, ref_result(o, a, b), rd, ref_latency(o, a, b));
      end
    end
  endtask

  // start held high throughout: ignored while busy and in DONE, next op accepted the cycle after DONE
  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2;
    logic [31:0] data_seen [4];
    int          k_seen    [4];
    int          wb_count;
    logic        idle_seen, acc2;
    a1 = $urandom; b1 = 32'($urandom_range(5000, 1));
    a2 = $urandom; b2 = $urandom_range(1) == 1 ? 32'hFFFF_FFF3 : 32'd13;
    wb_count = 0; idle_seen = 1'b0; acc2 = 1'b0;
    start = 1'b1; op = 2'd1; rs1_data = a1; rs2_data = b1; rd_in = 5'd3;
    @(posedge clk); #1;
    op = 2'd2; rs1_data = a2; rs2_data = b2; rd_in = 5'd4;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (!wb_we_n) begin
        if (wb_count < 4) begin
          data_seen[wb_count] = wb_data;
          k_seen[wb_count] = k;
        end
        wb_count++;
      end
      if (k == 34) idle_seen = !busy;
      if (k == 35) begin
        acc2 = busy;
        start = 1'b0;
      end
    end
    tests_run++;
    if (wb_count !== 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_writeback_count: got %0d, required 2", wb_count);
    end
    tests_run++;
    if (idle_seen !== 1'b1 || acc2 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_accept_timing: idle after done=%b accepted next=%b, required 1 1", idle_seen, acc2);
    end
    if (wb_count >= 2) begin
      tests_run++;
      if (k_seen[0] !== 33 || data_seen[0] !== ref_result(2'd1, a1, b1)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_first: cycle=%0d data=%h, required cycle=33 data=%h", k_seen[0], data_seen[0], ref_result(2'd1, a1, b1));
      end
      tests_run++;
      if (k_seen[1] !== 68 || data_seen[1] !== ref_result(2'd2, a2, b2)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_second: cycle=%0d data=%h, required cycle=68 data=%h", k_seen[1], data_seen[1], ref_result(2'd2, a2, b2));
      end
    end
  endtask

  task automatic test_reset_abort;
    int bad;
    start = 1'b1; op = 2'd0; rs1_data = 32'hFFFF_FC18; rs2_data = 32'd7; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_busy_before: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_we_n !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_reset_values: busy=%b done=%b we_n=%b rd=%0d data=%h, required 0 0 1 0 0", busy, done, wb_we_n, wb_rd, wb_data);
    end
    bad = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (!wb_we_n || busy) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_writeback: %0d active cycles after abort, required 0", bad);
    end
  endtask

`ifdef DIV_FLUSH_EN
  task automatic test_flush;
    int bad;
    start = 1'b1; op = 2'd1; rs1_data = 32'd12345; rs2_data = 32'd17; rd_in = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_we_n !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_calc: busy=%b done=%b we_n=%b, required 0 0 1", busy, done, wb_we_n);
    end
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (!wb_we_n || busy) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL flush_no_writeback: %0d active cycles, required 0", bad);
    end
    start = 1'b1; op = 2'd1; rs1_data = 32'd5; rs2_data = 32'd0; rd_in = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    tests_run++;
    if (done !== 1'b1 || wb_we_n !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_done_cycle: done=%b we_n=%b, required 1 1", done, wb_we_n);
    end
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || wb_we_n !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_blocks_start: busy=%b we_n=%b, required 0 1", busy, wb_we_n);
    end
    start = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'd0;
    rs1_data = '0;
    rs2_data = '0;
    rd_in = '0;
`ifdef DIV_FLUSH_EN
    flush = 1'b0;
`endif
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
`ifdef DIV_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
